step_clock_ctrl: RTL and testbench

//  Transport/tempo controller that drives the 8-step one-hot drum sequencer.
//  - Divides clk into step ticks at a programmable period.
//  - Runs a STOPPED/PLAYING/PAUSED transport FSM.
//  - Emits exactly one sequencer command per step: go_right, go_left or seq_srst.
//  - Tracks the current step index and applies a forward loop length.
//  - Sits between the front-panel transport inputs and the sequencer's srst/go_left/go_right.

---
 rtl/step_clock_ctrl.sv | 162 ++++++++++++++++
 tb/tb_step_clock_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl: tempo divider and STOPPED/PLAYING/PAUSED transport for the 8-step one-hot
// drum sequencer; issues exactly one go_right / go_left / seq_srst command per step.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  ST_STOPPED  | halted at step 0, cnt held at 0, man_step steps once
//  ST_PLAYING  | cnt advances each cycle, a step fires when cnt >= period-1
//  ST_PAUSED   | position and cnt frozen, man_step steps once, play resumes
module step_clock_ctrl #(
    parameter int unsigned       TICK_W     = 24,
    parameter logic [TICK_W-1:0] DEF_PERIOD = 24'd6250000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              dir_rev,
    input  logic              man_step,
    input  logic [2:0]        loop_len,
    input  logic              period_ld,
    input  logic [TICK_W-1:0] period_in,
    output logic              go_right,
    output logic              go_left,
    output logic              seq_srst,
    output logic [2:0]        step_idx,
    output logic              beat,
    output logic              playing
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_PLAYING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TICK_W-1:0] r_cnt;
    logic [TICK_W-1:0] w_cnt_nxt;
    logic [TICK_W-1:0] r_period;
    logic [TICK_W-1:0] w_period_nxt;
    logic [2:0]        r_step_idx;
    logic [2:0]        w_idx_nxt;
    logic              r_go_right;
    logic              r_go_left;
    logic              r_seq_srst;
    logic              r_beat;
    logic              r_playing;
    logic              w_go_right_nxt;
    logic              w_go_left_nxt;
    logic              w_seq_srst_nxt;
    logic              w_beat_nxt;
    logic              w_tick;
    logic              w_do_step;
    logic [3:0]        w_loop_n;

    // Period is never below 2, so period-1 cannot wrap.
    assign w_tick   = (r_state == ST_PLAYING) && (r_cnt >= (r_period - TICK_W'(1)));
    assign w_loop_n = (loop_len == 3'd0) ? 4'd8 : {1'b0, loop_len};

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_period_nxt   = r_period;
        w_idx_nxt      = r_step_idx;
        w_go_right_nxt = 1'b0;
        w_go_left_nxt  = 1'b0;
        w_seq_srst_nxt = 1'b0;
        w_do_step      = 1'b0;

        // The tick compare above uses the old period, so a coincident load lands after the step.
        if (period_ld) begin
            w_period_nxt = (period_in < TICK_W'(2)) ? TICK_W'(2) : period_in;
        end

        if (stop) begin
            w_state_nxt    = ST_STOPPED;
            w_cnt_nxt      = '0;
            w_idx_nxt      = 3'd0;
            w_seq_srst_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_STOPPED: begin
                    w_cnt_nxt = '0;
                    w_do_step = man_step;
                    if (!pause && play) begin
                        w_state_nxt = ST_PLAYING;
                    end
                end
                ST_PLAYING: begin
                    if (w_tick) begin
                        w_cnt_nxt = '0;
                        w_do_step = 1'b1;
                    end else if (!pause) begin
                        w_cnt_nxt = r_cnt + TICK_W'(1);
                    end
                    if (pause) begin
                        w_state_nxt = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    w_do_step = man_step;
                    if (!pause && play) begin
                        w_state_nxt = ST_PLAYING;
                    end
                end
                default: begin
                    w_state_nxt = ST_STOPPED;
                    w_cnt_nxt   = '0;
                end
            endcase

            if (w_do_step) begin
                if (dir_rev) begin
                    w_go_left_nxt = 1'b1;
                    w_idx_nxt     = r_step_idx - 3'd1;
                end else if ({1'b0, r_step_idx} >= (w_loop_n - 4'd1)) begin
                    w_seq_srst_nxt = 1'b1;
                    w_idx_nxt      = 3'd0;
                end else begin
                    w_go_right_nxt = 1'b1;
                    w_idx_nxt      = r_step_idx + 3'd1;
                end
            end
        end

        w_beat_nxt = (w_go_right_nxt | w_go_left_nxt | w_seq_srst_nxt) && (w_idx_nxt == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_STOPPED;
            r_cnt      <= '0;
            r_period   <= DEF_PERIOD;
            r_step_idx <= 3'd0;
            r_go_right <= 1'b0;
            r_go_left  <= 1'b0;
            r_seq_srst <= 1'b0;
            r_beat     <= 1'b0;
            r_playing  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_period   <= w_period_nxt;
            r_step_idx <= w_idx_nxt;
            r_go_right <= w_go_right_nxt;
            r_go_left  <= w_go_left_nxt;
            r_seq_srst <= w_seq_srst_nxt;
            r_beat     <= w_beat_nxt;
            r_playing  <= (w_state_nxt == ST_PLAYING);
        end
    end

    assign go_right = r_go_right;
    assign go_left  = r_go_left;
    assign seq_srst = r_seq_srst;
    assign step_idx = r_step_idx;
    assign beat     = r_beat;
    assign playing  = r_playing;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Scoreboard bench for step_clock_ctrl: directed transport scenarios then randomized traffic,
// predicted by a behavioural model and checked by an independent monitor.
module tb_step_clock_ctrl;

    localparam int TICK_W = 24;
    localparam int DEF    = 6250000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              play = 1'b0;
    logic              pause = 1'b0;
    logic              stop = 1'b0;
    logic              dir_rev = 1'b0;
    logic              man_step = 1'b0;
    logic [2:0]        loop_len = 3'd0;
    logic              period_ld = 1'b0;
    logic [TICK_W-1:0] period_in = '0;
    logic              go_right;
    logic              go_left;
    logic              seq_srst;
    logic [2:0]        step_idx;
    logic              beat;
    logic              playing;

    step_clock_ctrl #(.TICK_W(TICK_W)) dut (
        .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
        .dir_rev(dir_rev), .man_step(man_step), .loop_len(loop_len),
        .period_ld(period_ld), .period_in(period_in),
        .go_right(go_right), .go_left(go_left), .seq_srst(seq_srst),
        .step_idx(step_idx), .beat(beat), .playing(playing)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // cmd codes: 1 = go_right, 2 = go_left, 3 = seq_srst
    typedef struct { int cyc; int cmd; int idx; bit beat; } cmd_t;
    typedef struct { bit playing; int idx; } lvl_t;
    cmd_t cmd_q[$];
    lvl_t lvl_q[$];

    int checks = 0;
    int failures = 0;

    // Reference model: whether we are running, elapsed cycles in the current period, period, position.
    bit m_run = 0;
    int m_cnt = 0;
    int m_per = DEF;
    int m_idx = 0;

    task automatic model_step();
        int   cmd = 0;
        bit   stepnow = 0;
        int   len;
        int   newper;
        cmd_t e;
        lvl_t l;
        if (rst) begin
            m_run = 0; m_cnt = 0; m_per = DEF; m_idx = 0;
        end else begin
            newper = period_ld ? ((period_in < 2) ? 2 : int'(period_in)) : m_per;
            if (stop) begin
                cmd = 3; m_idx = 0; m_run = 0; m_cnt = 0;
            end else if (m_run) begin
                if (m_cnt + 1 >= m_per) begin
                    m_cnt = 0; stepnow = 1;
                end else if (!pause) begin
                    m_cnt = m_cnt + 1;
                end
                if (pause) m_run = 0;
            end else begin
                stepnow = man_step;
                if (play && !pause) m_run = 1;
            end
            if (stepnow) begin
                len = (loop_len == 0) ? 8 : int'(loop_len);
                if (dir_rev) begin
                    cmd = 2; m_idx = (m_idx + 7) % 8;
                end else if (m_idx + 1 >= len) begin
                    cmd = 3; m_idx = 0;
                end else begin
                    cmd = 1; m_idx = m_idx + 1;
                end
            end
            m_per = newper;
        end
        l.playing = m_run; l.idx = m_idx;
        lvl_q.push_back(l);
        if (cmd != 0) begin
            e.cyc = edge_cnt + 1; e.cmd = cmd; e.idx = m_idx; e.beat = (m_idx == 0);
            cmd_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin : monitor
        cmd_t e;
        lvl_t l;
        int   n_cmd;
        int   d_cmd;
        if (edge_cnt >= 1 && lvl_q.size() > 0) begin
            l = lvl_q.pop_front();
            checks++;
            if (playing !== l.playing) begin
                failures++;
                $display("FAIL playing @%0d: got %0b expected %0b", edge_cnt, playing, l.playing);
            end
            checks++;
            if (step_idx !== 3'(l.idx)) begin
                failures++;
                $display("FAIL step_idx @%0d: got %0d expected %0d", edge_cnt, step_idx, l.idx);
            end
            n_cmd = int'(go_right) + int'(go_left) + int'(seq_srst);
            d_cmd = go_right ? 1 : (go_left ? 2 : (seq_srst ? 3 : 0));
            checks++;
            if (n_cmd > 1) begin
                failures++;
                $display("FAIL cmd_exclusive @%0d: got %0d pulses expected at most 1", edge_cnt, n_cmd);
            end
            if (n_cmd != 0) begin
                checks++;
                if (cmd_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_cmd @%0d: got cmd %0d expected none", edge_cnt, d_cmd);
                end else begin
                    e = cmd_q.pop_front();
                    if (e.cyc != edge_cnt || e.cmd != d_cmd || e.idx != int'(step_idx) || e.beat != beat) begin
                        failures++;
                        $display("FAIL cmd @%0d: got cyc=%0d cmd=%0d idx=%0d beat=%0b expected cyc=%0d cmd=%0d idx=%0d beat=%0b",
                                 edge_cnt, edge_cnt, d_cmd, step_idx, beat, e.cyc, e.cmd, e.idx, e.beat);
                    end
                end
            end else begin
                checks++;
                if (beat !== 1'b0) begin
                    failures++;
                    $display("FAIL beat_without_cmd @%0d: got %0b expected 0", edge_cnt, beat);
                end
                if (cmd_q.size() > 0 && cmd_q[0].cyc <= edge_cnt) begin
                    e = cmd_q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_cmd @%0d: got none expected cmd=%0d at cyc=%0d", edge_cnt, e.cmd, e.cyc);
                end
            end
        end
    end

    task automatic go();
        model_step();
        @(posedge clk);
        #1;
        rst = 0; play = 0; pause = 0; stop = 0; man_step = 0; period_ld = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) go();
    endtask

    task automatic load_period(input int p);
        period_ld = 1; period_in = TICK_W'(p);
    endtask

    initial begin
        // reset
        rst = 1; go();
        rst = 1; go();
        checks++;
        if ({go_right, go_left, seq_srst, beat, playing} !== 5'b0 || step_idx !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b idx=%0d expected 00000 idx=0",
                     {go_right, go_left, seq_srst, beat, playing}, step_idx);
        end

        // 1: P=4 forward, go_right every 4 cycles
        load_period(4); go();
        play = 1; go();
        idle(3);
        go();
        checks++;
        if (go_right !== 1'b1 || step_idx !== 3'd1 || playing !== 1'b1) begin
            failures++;
            $display("FAIL first_step: got right=%0b idx=%0d playing=%0b expected 1 1 1", go_right, step_idx, playing);
        end
        idle(9);
        stop = 1; go();

        // 2: loop_len=3, P=2
        loop_len = 3'd3; load_period(2); go();
        play = 1; go();
        idle(14);
        stop = 1; go();

        // 3: reverse from step 0 ignores loop_len
        dir_rev = 1; man_step = 1; go();
        checks++;
        if (go_left !== 1'b1 || step_idx !== 3'd7) begin
            failures++;
            $display("FAIL reverse_wrap: got left=%0b idx=%0d expected 1 7", go_left, step_idx);
        end
        idle(2);
        dir_rev = 0; loop_len = 3'd0;
        stop = 1; go();

        // 4: pause at cnt=2 with P=8, hold, resume
        load_period(8); go();
        play = 1; go();
        idle(2);
        pause = 1; go();
        idle(20);
        play = 1; go();
        idle(10);

        // 5: stop + man_step while PAUSED at step 5
        stop = 1; go();
        play = 1; go();
        pause = 1; go();
        for (int i = 0; i < 5; i++) begin
            man_step = 1; go();
            go();
        end
        stop = 1; man_step = 1; go();
        checks++;
        if (seq_srst !== 1'b1 || go_right !== 1'b0 || step_idx !== 3'd0 || playing !== 1'b0) begin
            failures++;
            $display("FAIL stop_vs_man: got srst=%0b right=%0b idx=%0d playing=%0b expected 1 0 0 0",
                     seq_srst, go_right, step_idx, playing);
        end

        // 6: period_ld 0 while PLAYING at cnt=5
        load_period(8); go();
        play = 1; go();
        idle(5);
        load_period(0); go();
        idle(8);
        stop = 1; go();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) rst = 1;
            if ($urandom_range(0, 9) == 0) play = 1;
            if ($urandom_range(0, 19) == 0) pause = 1;
            if ($urandom_range(0, 32) == 0) stop = 1;
            if (!play && $urandom_range(0, 11) == 0) man_step = 1;
            if ($urandom_range(0, 19) == 0) dir_rev = ~dir_rev;
            if ($urandom_range(0, 19) == 0) loop_len = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 24) == 0) load_period($urandom_range(0, 9));
            go();
        end

        idle(4);
        checks++;
        if (cmd_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending commands expected 0", cmd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
